instr_mem_ctrl: RTL and testbench

Parametrised instruction memory with a pipelined fetch port and a streaming program-load port, replacing the fixed 256x16 hard-coded store in the pipeline front end. On reset it clears every word to NOP through an internal init sweep. It then serves one-cycle-latency fetches to the IF stage and accepts program images from the host/debug loader at any base address.

---
 rtl/instr_mem_ctrl.sv | 131 +++++++++++++
 tb/tb_instr_mem_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ctrl.sv
// Parametrised instruction memory: init sweep to NOP, 1-cycle fetch port, streaming loader.
// Optional IMEM_PARITY_EN adds an even-parity bit per word and the load_par_inv test hook.
module instr_mem_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
`ifdef IMEM_PARITY_EN
    input  logic              load_par_inv,
`endif
    output logic              init_done,
    output logic              parity_err
);
    localparam int DEPTH = 2**ADDR_W;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {INIT, IDLE, LOAD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              we;
    logic [DATA_W-1:0] wdata_d;
    logic [MEM_W-1:0]  wdata;
    logic              fetch_acc;
    logic [MEM_W-1:0]  mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // The shared ptr serves both the clear sweep and the load stream.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        we          = 1'b0;
        wdata_d     = NOP_WORD;
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        case (state)
            INIT: begin
                we      = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (&ptr) state_nxt = IDLE;
            end
            IDLE: begin
                fetch_ready = !load_start;
                if (load_start) begin
                    ptr_nxt   = load_base;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    we      = 1'b1;
                    wdata_d = load_data;
                    ptr_nxt = ptr + 1'b1;
                    if (load_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

`ifdef IMEM_PARITY_EN
    logic par_inv;
    assign par_inv = (state == LOAD) & load_par_inv;
    assign wdata   = {(^wdata_d) ^ par_inv, wdata_d};
`else
    assign wdata   = wdata_d;
`endif

    assign fetch_acc = fetch_ready & fetch_req;
    assign init_done = (state != INIT);

    always_ff @(posedge clk) begin
        if (we) mem[ptr] <= wdata;
    end

`ifdef IMEM_PARITY_EN
    logic fetch_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_data  <= NOP_WORD;
            fetch_par   <= 1'b0;
        end else begin
            fetch_valid <= fetch_acc;
            if (fetch_acc) {fetch_par, fetch_data} <= mem[fetch_addr];
        end
    end

    assign parity_err = fetch_valid & (fetch_par ^ (^fetch_data));
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_data  <= NOP_WORD;
        end else begin
            fetch_valid <= fetch_acc;
            if (fetch_acc) fetch_data <= mem[fetch_addr];
        end
    end

    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: expected fetch words are queued at acceptance
// and popped when fetch_valid is observed.
module tb_instr_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        load_start;
    logic [7:0]  load_base;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        par_inv;
    logic        init_done;
    logic        parity_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];
    logic [15:0] ldq[$];

`ifdef IMEM_PARITY_EN
    localparam logic PAR_HOOK = 1'b1;
`else
    localparam logic PAR_HOOK = 1'b0;
`endif

    instr_mem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
`ifdef IMEM_PARITY_EN
        .load_par_inv(par_inv),
`endif
        .init_done   (init_done),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Drives one fetch, waits (bounded) for acceptance, queues the expected word.
    task automatic issue_fetch(input logic [7:0] a, input logic [15:0] exp_d, input logic exp_p);
        int waited = 0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        while (!fetch_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!fetch_ready) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_accept_timeout addr=%h: ready=%b required 1", a, fetch_ready);
            fetch_req = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({exp_p, exp_d});
        #1 fetch_req = 1'b0;
    endtask

    task automatic drive_load(input logic [7:0] base, input logic [15:0] w[$], input logic pinv,
                              input bit finish);
        @(negedge clk);
        load_start = 1'b1;
        load_base  = base;
        @(posedge clk);
        #1 load_start = 1'b0;
        foreach (w[i]) begin
            load_valid = 1'b1;
            load_data  = w[i];
            load_last  = finish && (i == w.size() - 1);
            par_inv    = pinv;
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        par_inv    = 1'b0;
    endtask

    task automatic test_reset;
        int cyc = 0;
        int got = 0;
        int t = 0;
        logic [16:0] e;
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0; load_base = '0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0; par_inv = 1'b0;
        #12;
        n_cmp++;
        if ({fetch_ready, fetch_valid, load_ready, init_done, parity_err} !== 5'b0 || fetch_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: fr/fv/lr/id/pe=%b data=%h required 00000 / 0000",
                     {fetch_ready, fetch_valid, load_ready, init_done, parity_err}, fetch_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        while (!init_done && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        n_cmp++;
        if (cyc !== 256) begin
            n_err++;
            $display("FAIL init_cycles: got %0d required 256", cyc);
        end
        fork
            begin
                issue_fetch(8'h00, 16'h0000, 1'b0);
                issue_fetch(8'h7F, 16'h0000, 1'b0);
            end
            begin
                while (got < 2 && t < 40) begin
                    @(negedge clk);
                    t++;
                    if (fetch_valid && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (fetch_data !== e[15:0] || parity_err !== e[16]) begin
                            n_err++;
                            $display("FAIL init_fetch: data=%h pe=%b required %h %b", fetch_data, parity_err, e[15:0], e[16]);
                        end
                        got++;
                    end
                end
                if (got < 2) begin
                    n_cmp++; n_err++;
                    $display("FAIL init_fetch_timeout: got %0d results required 2", got);
                end
            end
        join
        @(negedge clk);
        issue_fetch(8'hFF, 16'h0000, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (fetch_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++;
            $display("FAIL fetch_latency: valid=%b one cycle after accept, required 1", fetch_valid);
        end else begin
            e = exp_q.pop_front();
            if (fetch_data !== e[15:0]) begin
                n_err++;
                $display("FAIL fetch_ff: data=%h required %h", fetch_data, e[15:0]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (fetch_valid !== 1'b0 || fetch_data !== 16'h0000) begin
            n_err++;
            $display("FAIL fetch_hold: valid=%b data=%h required 0 / 0000", fetch_valid, fetch_data);
        end
    endtask

    task automatic test_back_to_back;
        int t = 0;
        logic [16:0] e;
        ldq = '{16'h4C04, 16'h1100, 16'h1204};
        drive_load(8'h00, ldq, 1'b0, 1'b1);
        @(negedge clk);
        fork
            begin
                issue_fetch(8'h00, 16'h4C04, 1'b0);
                issue_fetch(8'h01, 16'h1100, 1'b0);
                issue_fetch(8'h02, 16'h1204, 1'b0);
                issue_fetch(8'h03, 16'h0000, 1'b0);
            end
            begin
                @(negedge clk);
                while (!fetch_valid && t < 40) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    n_cmp++;
                    if (!fetch_valid || exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL b2b_valid[%0d]: valid=%b required 1 on consecutive cycles", k, fetch_valid);
                    end else begin
                        e = exp_q.pop_front();
                        if (fetch_data !== e[15:0]) begin
                            n_err++;
                            $display("FAIL b2b_data[%0d]: data=%h required %h", k, fetch_data, e[15:0]);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_wrap;
        int got = 0;
        int t = 0;
        logic [16:0] e;
        ldq = '{16'hAAAA, 16'h5555};
        drive_load(8'hFF, ldq, 1'b0, 1'b1);
        @(negedge clk);
        fork
            begin
                issue_fetch(8'hFF, 16'hAAAA, 1'b0);
                issue_fetch(8'h00, 16'h5555, 1'b0);
                issue_fetch(8'h01, 16'h1100, 1'b0);
            end
            begin
                while (got < 3 && t < 40) begin
                    @(negedge clk);
                    t++;
                    if (fetch_valid && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (fetch_data !== e[15:0]) begin
                            n_err++;
                            $display("FAIL wrap_fetch[%0d]: data=%h required %h", got, fetch_data, e[15:0]);
                        end
                        got++;
                    end
                end
                if (got < 3) begin
                    n_cmp++; n_err++;
                    $display("FAIL wrap_timeout: got %0d results required 3", got);
                end
            end
        join
    endtask

    task automatic test_load_vs_fetch;
        logic [16:0] e;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 8'h20;
        load_start = 1'b1; load_base = 8'h20;
        #1;
        n_cmp++;
        if (fetch_ready !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_ready: fetch_ready=%b required 0", fetch_ready);
        end
        @(posedge clk);
        #1 load_start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fetch_valid !== 1'b0 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_state: fetch_valid=%b load_ready=%b required 0 / 1", fetch_valid, load_ready);
        end
        load_valid = 1'b1; load_data = 16'hBEEF; load_last = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0; load_last = 1'b0;
        n_cmp++;
        if (fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_load_ready: fetch_ready=%b required 1", fetch_ready);
        end
        @(posedge clk);
        exp_q.push_back({1'b0, 16'hBEEF});
        #1 fetch_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!fetch_valid || exp_q.size() == 0) begin
            n_err++;
            $display("FAIL post_load_fetch: valid=%b required 1", fetch_valid);
        end else begin
            e = exp_q.pop_front();
            if (fetch_data !== e[15:0]) begin
                n_err++;
                $display("FAIL post_load_data: data=%h required %h", fetch_data, e[15:0]);
            end
        end
    endtask

    task automatic test_parity;
        int got = 0;
        int t = 0;
        logic [16:0] e;
        ldq = '{16'hFD06};
        drive_load(8'h04, ldq, 1'b1, 1'b1);
        @(negedge clk);
        fork
            begin
                issue_fetch(8'h04, 16'hFD06, PAR_HOOK);
                issue_fetch(8'h05, 16'h0000, 1'b0);
            end
            begin
                while (got < 2 && t < 40) begin
                    @(negedge clk);
                    t++;
                    if (fetch_valid && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (fetch_data !== e[15:0] || parity_err !== e[16]) begin
                            n_err++;
                            $display("FAIL parity_fetch[%0d]: data=%h pe=%b required %h %b",
                                     got, fetch_data, parity_err, e[15:0], e[16]);
                        end
                        got++;
                    end
                end
                if (got < 2) begin
                    n_cmp++; n_err++;
                    $display("FAIL parity_timeout: got %0d results required 2", got);
                end
            end
        join
    endtask

    task automatic test_reset_mid_load;
        int cyc = 0;
        int got = 0;
        int t = 0;
        logic [16:0] e;
        ldq = '{16'h1234, 16'h5678};
        drive_load(8'h10, ldq, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (init_done !== 1'b0 || load_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midload_reset: init_done=%b load_ready=%b required 0 / 0", init_done, load_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        while (!init_done && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        @(negedge clk);
        fork
            begin
                issue_fetch(8'h10, 16'h0000, 1'b0);
                issue_fetch(8'h11, 16'h0000, 1'b0);
            end
            begin
                while (got < 2 && t < 40) begin
                    @(negedge clk);
                    t++;
                    if (fetch_valid && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (fetch_data !== e[15:0]) begin
                            n_err++;
                            $display("FAIL reinit_fetch[%0d]: data=%h required %h", got, fetch_data, e[15:0]);
                        end
                        got++;
                    end
                end
                if (got < 2) begin
                    n_cmp++; n_err++;
                    $display("FAIL reinit_timeout: got %0d results required 2", got);
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_load_vs_fetch();
        test_parity();
        test_reset_mid_load();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
